stopwatch_core_mux: RTL and testbench
=====================================

// Module: stopwatch_core_mux
// PURPOSE
//  Parametrised BCD stopwatch: tick prescaler, N-digit synchronous BCD counter chain,
//  start/stop/clear FSM and time-multiplexed active-low 7-segment drive. Sits between
//  debounced board buttons and the 7-seg/anode pins. All logic runs on clk only; no
//  derived or ripple clocks. Digit carries are clock enables.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency.
//  TICK_HZ     1000        count rate; TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2.
//  NUM_DIGITS  4           BCD digits counted and displayed (1..8).
//  REFRESH_DIV 4096        clk cycles each digit is lit during scan (>= 2).
//  DP_POS      3           digit index showing decimal point; >= NUM_DIGITS means no dp.
// PORTS
//  clk       in   1           system clock.
//  reset     in   1           synchronous, active-low reset.
//  start     in   1           level, debounced upstream; rising edge acts.
//  stop      in   1           level, debounced upstream; rising edge acts.
//  clear     in   1           level; rising edge acts.
//  lap       in   1           level; rising edge acts (only with LAP_HOLD_EN).
//  segment   out  7           active-low cathodes {g,f,e,d,c,b,a}.
//  an        out  NUM_DIGITS  active-low one-hot anode select.
//  dp        out  1           active-low decimal point.
//  running   out  1           1 while FSM is RUN.
//  overflow  out  1           sticky: count wrapped past all-9s.
// BEHAVIOUR
//  Reset (reset==0 at posedge): FSM=IDLE, digits=0, prescaler=0, scan index=0,
//   an=all 1, segment=7'h7F, dp=1, running=0, overflow=0, hold=0, edge regs=0.
//  Edge detect: one register per button; event = in & ~in_q. 1-cycle detect latency.
//  FSM IDLE -> RUN on start. RUN -> PAUSE on stop. PAUSE -> RUN on start.
//   PAUSE/IDLE -> IDLE on clear (digits, prescaler, overflow zeroed). clear in RUN ignored.
//   start+stop same cycle: stop wins (RUN->PAUSE; IDLE/PAUSE unchanged).
//  Prescaler counts 0..TICK_DIV-1 only in RUN; tick=1 for one cycle at TICK_DIV-1, then 0.
//   Held in PAUSE, so resume keeps the partial period.
//  Digit i increments on tick when digits 0..i-1 all ==9; a 9 wraps to 0 in the same cycle.
//   All digits ==9 + tick: all go to 0, overflow<=1, counting continues.
//  Scan: divider 0..REFRESH_DIV-1; at wrap, index advances, NUM_DIGITS-1 -> 0.
//   segment/an/dp registered, 1 cycle after index change. an[idx]=0, others 1.
//   dp=0 only when idx==DP_POS.
//  Reset mid-run: full return to reset state on next posedge; no residual tick.
// CONFIGURATION
//  LAP_HOLD_EN defined: lap edge in RUN toggles hold. Rising hold copies live digits into
//   a display bank, which is shown while counting continues. clear (in IDLE/PAUSE) or reset
//   drops hold. stop leaves hold unchanged. lap outside RUN is ignored.
//  LAP_HOLD_EN undefined: lap port present but ignored. No hold register or bank.
//   Display always shows live digits.
// STRUCTURE
//  Package stopwatch_pkg: FSM state codes (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2), 7-seg
//   glyph constants 0-9 and BLANK=7'h7F, clog2 function for index/divider widths.
//  Sub-module seg7_decode: combinational 4-bit BCD -> active-low 7-seg. Non-BCD -> BLANK.
//   Instantiated once, on the muxed digit.
// TESTING (sim params CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10, REFRESH_DIV=4)
//  1 reset low 3 cycles -> an=4'b1111, segment=7'h7F, dp=1, running=0, overflow=0.
//  2 start edge, wait 1230 clk, stop edge -> digits 0123. 50 more clk -> still 0123;
//    running=0; scan continues with an cycling 1110,1101,1011,0111.
//  3 run 10000 ticks from 0000 -> digits 0000, overflow=1, running=1.
//    stop, clear -> 0000, overflow=0, FSM IDLE.
//  4 start+stop same cycle in RUN -> PAUSE. In IDLE -> stays IDLE.
//    clear while RUN at 0050 -> ignored, keeps counting.
//  5 reset low at 0077 mid-run -> next cycle digits 0000, running=0, prescaler 0.
//  6 LAP_HOLD_EN: lap at 0042, run 100 ticks -> displayed 0042, internal 0142.
//    Second lap -> displayed 0142.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state codes, active-low 7-seg glyphs
// ({g,f,e,d,c,b,a}) and a width helper for counters and indices.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // ceil(log2(v)), never below 1 so a 1-entry range still gets a real bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment cathodes; non-BCD codes show blank.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // pure lookup, no state
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_core_mux.sv
// BCD stopwatch core: tick prescaler, synchronous BCD digit chain, start/stop/
// clear FSM and a scanned active-low 7-seg driver. Single clock; digit carries
// are clock enables. Optional lap/hold display bank when LAP_HOLD_EN is defined.
module stopwatch_core_mux
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4096,
  parameter int DP_POS      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [6:0]            segment,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  running,
  output logic                  overflow
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PSC_W    = clog2(TICK_DIV);
  localparam int REF_W    = clog2(REFRESH_DIV);
  localparam int IDX_W    = clog2(NUM_DIGITS);

  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DIV - 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam bit               DP_EN   = (DP_POS >= 0) && (DP_POS < NUM_DIGITS);
  localparam logic [IDX_W-1:0] DP_IDX  = DP_EN ? IDX_W'(DP_POS) : '0;

  sw_state_e                  state;
  logic                       start_q, stop_q, clear_q;
  logic                       start_ev, stop_ev, clear_ev, clr_act;
  logic [PSC_W-1:0]           psc;
  logic                       tick;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0][3:0] disp_digits;
  logic [NUM_DIGITS:0]        carry;
  logic [REF_W-1:0]           ref_cnt;
  logic [IDX_W-1:0]           idx;
  logic [3:0]                 cur_bcd;
  logic [6:0]                 cur_seg;
  logic [NUM_DIGITS-1:0]      an_next;

  assign start_ev = start & ~start_q;
  assign stop_ev  = stop  & ~stop_q;
  assign clear_ev = clear & ~clear_q;
  // clear only acts while stopped; in RUN it is dropped
  assign clr_act  = clear_ev && (state != ST_RUN);
  assign tick     = (state == ST_RUN) && (psc == PSC_MAX);

  // one delay register per button for rising-edge detect
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      clear_q <= clear;
    end
  end

  // control FSM; running is registered alongside the state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else if (clr_act) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_ev && !stop_ev) begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        ST_RUN: if (stop_ev) begin
          state   <= ST_PAUSE;
          running <= 1'b0;
        end
        ST_PAUSE: if (start_ev && !stop_ev) begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // prescaler advances only in RUN, so a pause keeps the partial period
  always_ff @(posedge clk) begin
    if (!reset || clr_act)  psc <= '0;
    else if (state == ST_RUN) psc <= tick ? '0 : psc + PSC_W'(1);
  end

  // ripple-free carry: digit i enabled when tick and all lower digits are 9
  always_comb begin
    carry    = '0;
    carry[0] = tick;
    for (int i = 0; i < NUM_DIGITS; i++)
      carry[i+1] = carry[i] & (digits[i] == 4'd9);
  end

  // BCD digit chain; a carry out of the top digit wraps everything to 0
  always_ff @(posedge clk) begin
    if (!reset || clr_act) begin
      digits <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (carry[i]) digits[i] <= (digits[i] == 4'd9) ? 4'd0 : digits[i] + 4'd1;
    end
  end

  // sticky wrap flag
  always_ff @(posedge clk) begin
    if (!reset || clr_act) overflow <= 1'b0;
    else if (carry[NUM_DIGITS]) overflow <= 1'b1;
  end

`ifdef LAP_HOLD_EN
  logic                       lap_q, lap_ev, hold;
  logic [NUM_DIGITS-1:0][3:0] bank;

  assign lap_ev = lap & ~lap_q;

  // lap edge register
  always_ff @(posedge clk) begin
    if (!reset) lap_q <= 1'b0;
    else        lap_q <= lap;
  end

  // hold toggles on lap in RUN; entering hold snapshots the live count
  always_ff @(posedge clk) begin
    if (!reset || clr_act) begin
      hold <= 1'b0;
      bank <= '0;
    end else if (lap_ev && state == ST_RUN) begin
      hold <= ~hold;
      if (!hold) bank <= digits;
    end
  end

  assign disp_digits = hold ? bank : digits;
`else
  logic lap_unused;
  assign lap_unused  = lap;
  assign disp_digits = digits;
`endif

  // scan divider; digit index steps once per REFRESH_DIV cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REF_MAX) begin
      ref_cnt <= '0;
      idx     <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  assign cur_bcd = disp_digits[idx];

  seg7_decode u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  // active-low one-hot anode for the current index
  always_comb begin
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IDX_W'(i)) an_next[i] = 1'b0;
  end

  // registered pin drive, one cycle behind the index
  always_ff @(posedge clk) begin
    if (!reset) begin
      segment <= SEG_BLANK;
      an      <= '1;
      dp      <= 1'b1;
    end else begin
      segment <= cur_seg;
      an      <= an_next;
      dp      <= ~(DP_EN && (idx == DP_IDX));
    end
  end

endmodule

// File: tb/tb_stopwatch_core_mux.sv
// Directed bench for stopwatch_core_mux: a 4-digit instance (TICK_DIV=10,
// REFRESH_DIV=4) for control/scan behaviour and a 2-digit instance
// (TICK_DIV=2, no dp) for the overflow wrap.
module tb_stopwatch_core_mux;

  localparam int OP_NONE  = 0;
  localparam int OP_START = 1;
  localparam int OP_STOP  = 2;
  localparam int OP_CLEAR = 3;
  localparam int OP_BOTH  = 4;
  localparam int OP_LAP   = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [6:0] segment;
  logic [3:0] an;
  logic dp, running, overflow;

  logic start2 = 1'b0, stop2 = 1'b0, clear2 = 1'b0, lap2 = 1'b0;
  logic [6:0] segment2;
  logic [1:0] an2;
  logic dp2, running2, overflow2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_core_mux #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(4),
                       .REFRESH_DIV(4), .DP_POS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .segment(segment), .an(an), .dp(dp), .running(running),
    .overflow(overflow));

  stopwatch_core_mux #(.CLK_HZ(2), .TICK_HZ(1), .NUM_DIGITS(2),
                       .REFRESH_DIV(2), .DP_POS(5)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2), .clear(clear2),
    .lap(lap2), .segment(segment2), .an(an2), .dp(dp2), .running(running2),
    .overflow(overflow2));

  typedef struct {
    int         op;
    int         wait_cyc;
    logic       exp_run;
    logic       exp_ovf;
    logic [15:0] exp_dig;
    bit         disp_chk;
  } vec_t;

  vec_t vecs [11];

  logic [6:0] glyph [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one-cycle pulse on the chosen button(s) of the main instance
  task automatic press(input int op);
    case (op)
      OP_START: start = 1'b1;
      OP_STOP:  stop  = 1'b1;
      OP_CLEAR: clear = 1'b1;
      OP_BOTH:  begin start = 1'b1; stop = 1'b1; end
      OP_LAP:   lap   = 1'b1;
      default:  ;
    endcase
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  // watch 24 cycles of scan and rebuild the displayed 4-digit value
  task automatic read_disp(output logic [15:0] val, output bit ok, output bit an_ok, output bit dp_ok);
    logic [3:0] prev, seen;
    int d, g, changes;
    val = '0; seen = '0; ok = 1'b1; an_ok = 1'b1; dp_ok = 1'b1; changes = 0;
    prev = an;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d < 0) ok = 1'b0;
      else begin
        g = -1;
        for (int k = 0; k < 10; k++) if (segment == glyph[k]) g = k;
        if (g < 0) ok = 1'b0;
        else begin
          val[d*4 +: 4] = 4'(g);
          seen[d] = 1'b1;
        end
        if (dp != (d != 3)) dp_ok = 1'b0;
      end
      if (an != prev) begin
        changes++;
        if (an != {prev[2:0], prev[3]}) an_ok = 1'b0;
        prev = an;
      end
    end
    if (seen != 4'b1111 || changes < 4) ok = 1'b0;
  endtask

  task automatic disp_check(input string name, input logic [15:0] exp);
    logic [15:0] v;
    bit ok, a_ok, d_ok;
    read_disp(v, ok, a_ok, d_ok);
    check({name, "_val"}, {15'd0, ok, v}, {15'd0, 1'b1, exp});
    check({name, "_an"}, {31'd0, a_ok}, 32'd1);
    check({name, "_dp"}, {31'd0, d_ok}, 32'd1);
  endtask

  initial begin
    logic [15:0] v;
    bit dp2_ok;

    glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
    glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
    glyph[8] = 7'h00; glyph[9] = 7'h10;

    // op, wait after the pulse, running, overflow, digits, display check
    vecs[0]  = '{OP_START, 1229, 1'b1, 1'b0, 16'h0122, 1'b0};
    vecs[1]  = '{OP_STOP,    50, 1'b0, 1'b0, 16'h0123, 1'b1};
    vecs[2]  = '{OP_START,   10, 1'b1, 1'b0, 16'h0124, 1'b0};
    vecs[3]  = '{OP_BOTH,     5, 1'b0, 1'b0, 16'h0124, 1'b1};
    vecs[4]  = '{OP_CLEAR,    2, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{OP_BOTH,    20, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[6]  = '{OP_START,  500, 1'b1, 1'b0, 16'h0050, 1'b0};
    vecs[7]  = '{OP_CLEAR,   29, 1'b1, 1'b0, 16'h0053, 1'b0};
    vecs[8]  = '{OP_STOP,     3, 1'b0, 1'b0, 16'h0053, 1'b1};
    vecs[9]  = '{OP_CLEAR,    2, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[10] = '{OP_START,  775, 1'b1, 1'b0, 16'h0077, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, segment}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_an2", {30'd0, an2}, 32'h3);
    reset = 1'b1;
    @(negedge clk);

    // overflow on the 2-digit instance: 100 ticks of 2 cycles each
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    dp2_ok = 1'b1;
    for (int n = 0; n < 199; n++) begin
      @(negedge clk);
      if (dp2 !== 1'b1) dp2_ok = 1'b0;
    end
    check("ovf_pre_dig", {24'd0, dut2.digits}, 32'h99);
    check("ovf_pre_flag", {31'd0, overflow2}, 32'd0);
    check("dp2_never_low", {31'd0, dp2_ok}, 32'd1);
    @(negedge clk);
    check("ovf_dig", {24'd0, dut2.digits}, 32'h00);
    check("ovf_flag", {31'd0, overflow2}, 32'd1);
    check("ovf_running", {31'd0, running2}, 32'd1);
    repeat (2) @(negedge clk);
    check("ovf_sticky_dig", {24'd0, dut2.digits}, 32'h01);
    check("ovf_sticky_flag", {31'd0, overflow2}, 32'd1);
    stop2 = 1'b1; @(negedge clk); stop2 = 1'b0;
    clear2 = 1'b1; @(negedge clk); clear2 = 1'b0;
    @(negedge clk);
    check("ovf_clr_flag", {31'd0, overflow2}, 32'd0);
    check("ovf_clr_dig", {24'd0, dut2.digits}, 32'h00);
    check("ovf_clr_running", {31'd0, running2}, 32'd0);

    // table-driven control sequence on the main instance
    for (int i = 0; i < 11; i++) begin
      press(vecs[i].op);
      repeat (vecs[i].wait_cyc) @(negedge clk);
      check($sformatf("vec%0d_running", i), {31'd0, running}, {31'd0, vecs[i].exp_run});
      check($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      check($sformatf("vec%0d_digits", i), {16'd0, dut.digits}, {16'd0, vecs[i].exp_dig});
      if (vecs[i].disp_chk) disp_check($sformatf("vec%0d_disp", i), vecs[i].exp_dig);
    end

    // reset mid-run at 0077
    reset = 1'b0;
    @(negedge clk);
    check("midrst_digits", {16'd0, dut.digits}, 32'h0);
    check("midrst_running", {31'd0, running}, 32'd0);
    check("midrst_psc", 32'(dut.psc), 32'd0);
    check("midrst_an", {28'd0, an}, 32'hF);
    check("midrst_seg", {25'd0, segment}, 32'h7F);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_digits", {16'd0, dut.digits}, 32'h0);
    check("postrst_psc", 32'(dut.psc), 32'd0);

`ifdef LAP_HOLD_EN
    // lap at 0042 freezes the display while counting continues
    press(OP_START);
    repeat (420) @(negedge clk);
    check("lap_pre_digits", {16'd0, dut.digits}, 32'h0042);
    press(OP_LAP);
    repeat (979) @(negedge clk);
    read_disp(v, dp2_ok, dp2_ok, dp2_ok);
    check("lap_held_disp", {16'd0, v}, 32'h0042);
    check("lap_live_digits", {16'd0, dut.digits}, 32'h0142);
    press(OP_LAP);
    press(OP_STOP);
    disp_check("lap_release_disp", 16'h0142);
`else
    // lap is ignored: display follows the live count
    press(OP_START);
    repeat (30) @(negedge clk);
    press(OP_LAP);
    press(OP_STOP);
    check("nolap_digits", {16'd0, dut.digits}, 32'h0003);
    disp_check("nolap_disp", 16'h0003);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
